// File: rtl/aha_tlx_training_ctrl.sv
// aha_tlx_training_ctrl
// ---------------------------------------------------------------------------
// TLX link training controller, SIB clock domain. Software programs a
// pattern and a beat count over AHB-Lite, then writes START. The block takes
// the forward payload channel (TRAIN_ACTIVE), streams the training sequence
// on TRAIN_T*, and checks the looped-back reverse stream beat by beat. It
// reports PASS / FAIL / TMO, a mismatch count and an RX beat count, and it
// raises an optional level interrupt.
//
// Optional feature macro: AHA_TLX_TRAIN_PRBS_EN
//   defined   : beat data is a 40-bit Fibonacci LFSR (x^40+x^38+x^21+x^19+1)
//               seeded from PATTERN (0 is replaced by 1), one LFSR per side.
//   undefined : beat i carries PATTERN + i (mod 2^40).
//
// Ports
//   TLX_SIB_CLK, TLX_SIB_RESETn : clock, synchronous active-low reset
//   TLX_H*                      : AHB-Lite slave, zero wait states, OKAY only
//   TRAIN_ACTIVE                : high while the FSM is ACTIVE
//   TRAIN_TVALID/TREADY/TDATA   : training TX stream, 40-bit beats
//   TRAIN_RX_TVALID/TREADY/TDATA: reverse stream, bits [39:0] are checked
//   TRAIN_IRQ                   : level interrupt, cleared by a STATUS write
//
// Register map (word offsets): 0x00 CTRL {IRQ_EN[8], ABORT[1], START[0]},
// 0x04 PATLO, 0x08 PATHI, 0x0C LENGTH, 0x10 TIMEOUT, 0x14 STATUS
// {BUSY[7], TMO[6], FAIL[5], PASS[4], state[1:0]}, 0x18 ERRCNT, 0x1C RXCNT.
//
// Handshake: a beat transfers on a rising clock edge where VALID and READY
// are both high; a source holds DATA stable while VALID is high and READY is
// low, and never withdraws VALID before the transfer.
// ---------------------------------------------------------------------------
module aha_tlx_training_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic        TLX_SIB_CLK,
    input  logic        TLX_SIB_RESETn,
    input  logic        TLX_HSELx,
    input  logic        TLX_HREADY,
    input  logic        TLX_HWRITE,
    input  logic [1:0]  TLX_HTRANS,
    input  logic [2:0]  TLX_HSIZE,
    input  logic [31:0] TLX_HADDR,
    input  logic [31:0] TLX_HWDATA,
    output logic [31:0] TLX_HRDATA,
    output logic        TLX_HREADYOUT,
    output logic        TLX_HRESP,
    output logic        TRAIN_ACTIVE,
    output logic        TRAIN_TVALID,
    input  logic        TRAIN_TREADY,
    output logic [39:0] TRAIN_TDATA,
    input  logic        TRAIN_RX_TVALID,
    output logic        TRAIN_RX_TREADY,
    input  logic [79:0] TRAIN_RX_TDATA,
    output logic        TRAIN_IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state, state_next;

    logic               dp_valid, dp_write;
    logic [2:0]         dp_addr;
    logic               irq_en, irq_r;
    logic [39:0]        pattern;
    logic [LEN_W-1:0]   length, timeout, errcnt, tx_idx, rx_idx, tmo_cnt;
    logic               pass_r, fail_r, tmo_r;

    logic               addr_phase, wr_en, start_req, abort_req, cfg_wr;
    logic               is_active, start_go, tx_fire, rx_fire, rx_mismatch;
    logic               all_done, tmo_hit, finish_ok;
    logic [LEN_W-1:0]   tx_idx_n, rx_idx_n, errcnt_n;
    logic [39:0]        tx_beat, rx_beat;
    logic [31:0]        rdata;

    // Bits of the bus and reverse stream that carry nothing for this block.
    logic unused_ok;
    assign unused_ok = ^{TLX_HSIZE, TLX_HADDR[31:5], TLX_HADDR[1:0], TRAIN_RX_TDATA[79:40]};

    // ---------------- AHB-Lite decode ----------------
    assign addr_phase = TLX_HSELx & TLX_HREADY & TLX_HTRANS[1];
    assign wr_en      = dp_valid & dp_write;
    assign start_req  = wr_en && (dp_addr == 3'd0) && TLX_HWDATA[0];
    assign abort_req  = wr_en && (dp_addr == 3'd0) && TLX_HWDATA[1];
    // Sequence configuration is frozen while a run is in progress.
    assign cfg_wr     = wr_en && (state != ST_ACTIVE);

    // ---------------- datapath ----------------
    assign is_active   = (state == ST_ACTIVE);
    assign start_go    = (state == ST_IDLE) && start_req;
    assign TRAIN_TVALID = is_active && (tx_idx < length);
    assign tx_fire     = TRAIN_TVALID && TRAIN_TREADY;
    // RX is always ready; beats outside a run or past LENGTH are dropped.
    assign rx_fire     = is_active && TRAIN_RX_TVALID && (rx_idx < length);
    assign rx_mismatch = rx_fire && (TRAIN_RX_TDATA[39:0] != rx_beat);
    assign errcnt_n    = (rx_mismatch && (errcnt != '1)) ? errcnt + LEN_W'(1) : errcnt;
    assign tx_idx_n    = tx_fire ? tx_idx + LEN_W'(1) : tx_idx;
    assign rx_idx_n    = rx_fire ? rx_idx + LEN_W'(1) : rx_idx;
    // Completion looks at this cycle's transfers so a final beat landing in
    // the timeout cycle is credited as completion, not timeout.
    assign all_done    = (tx_idx_n == length) && (rx_idx_n == length);
    // tmo_cnt counts idle ACTIVE cycles already spent; TIMEOUT cycles without
    // an accepted beat are allowed, then DONE follows.
    assign tmo_hit     = (timeout != '0) && !rx_fire && ((tmo_cnt + LEN_W'(1)) == timeout);
    assign finish_ok   = is_active && !abort_req && (all_done || tmo_hit);

`ifdef AHA_TLX_TRAIN_PRBS_EN
    function automatic logic [39:0] lfsr_step(input logic [39:0] s);
        return {s[38:0], s[39] ^ s[37] ^ s[20] ^ s[18]};
    endfunction

    logic [39:0] tx_lfsr, rx_lfsr, lfsr_seed;
    assign lfsr_seed = (pattern == 40'd0) ? 40'd1 : pattern;

    always_ff @(posedge TLX_SIB_CLK) begin
        if (!TLX_SIB_RESETn) begin
            tx_lfsr <= '0;
            rx_lfsr <= '0;
        end else if (start_go) begin
            tx_lfsr <= lfsr_seed;
            rx_lfsr <= lfsr_seed;
        end else begin
            if (tx_fire) tx_lfsr <= lfsr_step(tx_lfsr);
            if (rx_fire) rx_lfsr <= lfsr_step(rx_lfsr);
        end
    end

    assign tx_beat = tx_lfsr;
    assign rx_beat = rx_lfsr;
`else
    assign tx_beat = pattern + 40'(tx_idx);
    assign rx_beat = pattern + 40'(rx_idx);
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge TLX_SIB_CLK) begin
        if (!TLX_SIB_RESETn) state <= ST_IDLE;
        else                 state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_req) state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (abort_req)                state_next = ST_IDLE;
                else if (all_done || tmo_hit) state_next = ST_DONE;
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge TLX_SIB_CLK) begin
        if (!TLX_SIB_RESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            irq_en   <= 1'b0;
            irq_r    <= 1'b0;
            pattern  <= '0;
            length   <= '0;
            timeout  <= '0;
            errcnt   <= '0;
            tx_idx   <= '0;
            rx_idx   <= '0;
            tmo_cnt  <= '0;
            pass_r   <= 1'b0;
            fail_r   <= 1'b0;
            tmo_r    <= 1'b0;
        end else begin
            dp_valid <= addr_phase;
            if (addr_phase) begin
                dp_write <= TLX_HWRITE;
                dp_addr  <= TLX_HADDR[4:2];
            end

            if (wr_en && (dp_addr == 3'd0)) irq_en <= TLX_HWDATA[8];
            if (cfg_wr) begin
                case (dp_addr)
                    3'd1:    pattern[31:0]  <= TLX_HWDATA;
                    3'd2:    pattern[39:32] <= TLX_HWDATA[7:0];
                    3'd3:    length         <= TLX_HWDATA[LEN_W-1:0];
                    3'd4:    timeout        <= TLX_HWDATA[LEN_W-1:0];
                    default: ;
                endcase
            end

            if (start_go) begin
                pass_r  <= 1'b0;
                fail_r  <= 1'b0;
                tmo_r   <= 1'b0;
                errcnt  <= '0;
                tx_idx  <= '0;
                rx_idx  <= '0;
                tmo_cnt <= '0;
            end else if (is_active) begin
                tx_idx  <= tx_idx_n;
                rx_idx  <= rx_idx_n;
                errcnt  <= errcnt_n;
                tmo_cnt <= rx_fire ? '0 : tmo_cnt + LEN_W'(1);
                if (abort_req) begin
                    fail_r <= 1'b1;
                end else if (all_done) begin
                    pass_r <= (errcnt_n == '0);
                    fail_r <= (errcnt_n != '0);
                end else if (tmo_hit) begin
                    fail_r <= 1'b1;
                    tmo_r  <= 1'b1;
                end
            end

            // A new completion outranks a simultaneous clear.
            if (finish_ok && irq_en)                irq_r <= 1'b1;
            else if (wr_en && (dp_addr == 3'd5))    irq_r <= 1'b0;
        end
    end

    // ---------------- read mux and outputs ----------------
    always_comb begin
        rdata = '0;
        case (dp_addr)
            3'd0: rdata[8]   = irq_en;
            3'd1: rdata      = pattern[31:0];
            3'd2: rdata[7:0] = pattern[39:32];
            3'd3: rdata      = 32'(length);
            3'd4: rdata      = 32'(timeout);
            3'd5: rdata[7:0] = {is_active, tmo_r, fail_r, pass_r, 2'b00, state};
            3'd6: rdata      = 32'(errcnt);
            3'd7: rdata      = 32'(rx_idx);
            default: rdata   = '0;
        endcase
    end

    assign TLX_HRDATA      = rdata;
    assign TLX_HREADYOUT   = 1'b1;
    assign TLX_HRESP       = 1'b0;
    assign TRAIN_ACTIVE    = is_active;
    assign TRAIN_TDATA     = tx_beat;
    assign TRAIN_RX_TREADY = 1'b1;
    assign TRAIN_IRQ       = irq_r;

endmodule

// File: tb/tb_aha_tlx_training_ctrl.sv
// Bench for aha_tlx_training_ctrl: directed AHB register sequences with a
// scoreboard of expected read data and expected TX beats, popped by a monitor
// on the falling clock edge.
module tb_aha_tlx_training_ctrl;
    localparam int LEN_W = 16;
    localparam logic [31:0] A_CTRL = 32'h00, A_PATLO = 32'h04, A_PATHI = 32'h08,
                            A_LEN = 32'h0C, A_TMO = 32'h10, A_STAT = 32'h14,
                            A_ERR = 32'h18, A_RXC = 32'h1C;
    localparam logic [39:0] PAT_A = 40'h12_3456_7890;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic        hsel, hready, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hreadyout, hresp;
    logic        act, tvalid, tready, rx_valid, rx_tready, irq;
    logic [39:0] tdata;
    logic [79:0] rx_data;

    aha_tlx_training_ctrl #(.LEN_W(LEN_W)) dut (
        .TLX_SIB_CLK(clk), .TLX_SIB_RESETn(rstn),
        .TLX_HSELx(hsel), .TLX_HREADY(hready), .TLX_HWRITE(hwrite),
        .TLX_HTRANS(htrans), .TLX_HSIZE(hsize), .TLX_HADDR(haddr),
        .TLX_HWDATA(hwdata), .TLX_HRDATA(hrdata), .TLX_HREADYOUT(hreadyout),
        .TLX_HRESP(hresp), .TRAIN_ACTIVE(act), .TRAIN_TVALID(tvalid),
        .TRAIN_TREADY(tready), .TRAIN_TDATA(tdata), .TRAIN_RX_TVALID(rx_valid),
        .TRAIN_RX_TREADY(rx_tready), .TRAIN_RX_TDATA(rx_data), .TRAIN_IRQ(irq)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_rd_q[$];
    logic [7:0]  exp_ra_q[$];
    logic [39:0] exp_tx_q[$];
    logic        rd_phase = 1'b0;

    function automatic logic [39:0] lfsr_next(input logic [39:0] s);
        return {s[38:0], s[39] ^ s[37] ^ s[20] ^ s[18]};
    endfunction

    function automatic logic [39:0] exp_beat(input logic [39:0] pat, input int i);
`ifdef AHA_TLX_TRAIN_PRBS_EN
        logic [39:0] s;
        s = (pat == 40'd0) ? 40'd1 : pat;
        for (int k = 0; k < i; k++) s = lfsr_next(s);
        return s;
`else
        return pat + 40'(i);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_checks++;
        if (actual !== required) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rd_phase) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_unexpected actual=%h", hrdata);
            end else begin
                logic [31:0] e;
                logic [7:0]  a;
                e = exp_rd_q.pop_front();
                a = exp_ra_q.pop_front();
                if (hrdata !== e || hreadyout !== 1'b1 || hresp !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rd_%02h actual=%h required=%h hreadyout=%b hresp=%b",
                             a, hrdata, e, hreadyout, hresp);
                end
            end
        end
        if (rstn && tvalid && tready) begin
            n_checks++;
            if (exp_tx_q.size() == 0) begin
                n_errors++;
                $display("FAIL tx_unexpected actual=%h", tdata);
            end else begin
                logic [39:0] e;
                e = exp_tx_q.pop_front();
                if (tdata !== e) begin
                    n_errors++;
                    $display("FAIL tx_beat actual=%h required=%h", tdata, e);
                end
            end
        end
    end

    // ---------------- driver tasks (all start/end #1 after posedge) ----------------
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
        @(posedge clk); #1;
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] required);
        exp_rd_q.push_back(required);
        exp_ra_q.push_back(addr[7:0]);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = addr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; rd_phase = 1'b1;
        @(posedge clk); #1;
        rd_phase = 1'b0;
    endtask

    // Loops TX back to RX each cycle; flips bit0 of beat corrupt_beat.
    task automatic run_loopback(input int corrupt_beat, input int max_cyc, output int cyc);
        int beat;
        beat = 0;
        cyc = 0;
        while (act && cyc < max_cyc) begin
            rx_valid = tvalid & tready;
            rx_data  = {40'd0, tdata ^ ((beat == corrupt_beat) ? 40'd1 : 40'd0)};
            if (tvalid && tready) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic wait_active(input int max_cyc, output int cyc);
        cyc = 0;
        while (act && cyc < max_cyc) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic push_beats(input logic [39:0] pat, input int n);
        for (int i = 0; i < n; i++) exp_tx_q.push_back(exp_beat(pat, i));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rstn = 1'b0; hsel = 1'b0; hready = 1'b1; hwrite = 1'b0; htrans = 2'b00;
        hsize = 3'b010; haddr = '0; hwdata = '0; tready = 1'b1;
        rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", act, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_rx_tready", rx_tready, 1);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_hreadyout", hreadyout, 1);
        chk("rst_hresp", hresp, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) ahb_read(32'(a * 4), 32'h0);

        // Loopback, PATTERN 0x12_3456_7890, LENGTH 4
        ahb_write(A_PATLO, 32'h3456_7890);
        ahb_write(A_PATHI, 32'h12);
        ahb_write(A_LEN, 32'd4);
        ahb_write(A_TMO, 32'd0);
        push_beats(PAT_A, 4);
        ahb_write(A_CTRL, 32'h1);
        chk("start_active", act, 1);
        chk("start_tvalid", tvalid, 1);
        chk("start_tdata", tdata, 40'h12_3456_7890);
        run_loopback(-1, 20, cyc);
        chk("lb_active_cycles", cyc, 4);
        chk("lb_irq_disabled", irq, 0);
        ahb_read(A_STAT, 32'h10);
        ahb_read(A_ERR, 32'd0);
        ahb_read(A_RXC, 32'd4);

        // Corruption of beat 2 with IRQ enabled
        ahb_write(A_CTRL, 32'h100);
        push_beats(PAT_A, 4);
        ahb_write(A_CTRL, 32'h101);
        run_loopback(2, 20, cyc);
        chk("corrupt_active_cycles", cyc, 4);
        chk("corrupt_irq_set", irq, 1);
        ahb_read(A_STAT, 32'h20);
        ahb_read(A_ERR, 32'd1);
        ahb_read(A_RXC, 32'd4);
        ahb_read(A_CTRL, 32'h100);
        chk("corrupt_irq_held", irq, 1);
        ahb_write(A_STAT, 32'h0);
        chk("corrupt_irq_cleared", irq, 0);

        // Timeout: LENGTH 2, TIMEOUT 10, no RX
        ahb_write(A_LEN, 32'd2);
        ahb_write(A_TMO, 32'd10);
        push_beats(PAT_A, 2);
        ahb_write(A_CTRL, 32'h101);
        wait_active(40, cyc);
        chk("tmo_active_cycles", cyc, 10);
        chk("tmo_irq", irq, 1);
        ahb_read(A_STAT, 32'h60);
        ahb_read(A_RXC, 32'd0);
        ahb_read(A_ERR, 32'd0);
        ahb_write(A_STAT, 32'h0);
        ahb_write(A_TMO, 32'd0);

        // Backpressure then ABORT; PATLO write during the run is dropped
        ahb_write(A_LEN, 32'd4);
        tready = 1'b0;
        ahb_write(A_CTRL, 32'h101);
        for (int i = 0; i < 3; i++) begin
            chk("stall_tvalid", tvalid, 1);
            chk("stall_tdata", tdata, exp_beat(PAT_A, 0));
            @(posedge clk); #1;
        end
        ahb_write(A_PATLO, 32'hDEAD_BEEF);
        chk("stall_tdata_after_wr", tdata, exp_beat(PAT_A, 0));
        ahb_write(A_CTRL, 32'h102);
        chk("abort_active", act, 0);
        chk("abort_tvalid", tvalid, 0);
        tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_irq", irq, 0);
        ahb_read(A_STAT, 32'h20);
        ahb_read(A_PATLO, 32'h3456_7890);
        ahb_write(A_CTRL, 32'h0);

        // LENGTH 0: ACTIVE for one cycle, PASS, no beats
        ahb_write(A_LEN, 32'd0);
        ahb_write(A_CTRL, 32'h1);
        chk("len0_active", act, 1);
        chk("len0_tvalid", tvalid, 0);
        @(posedge clk); #1;
        chk("len0_done", act, 0);
        ahb_read(A_STAT, 32'h10);
        ahb_read(A_RXC, 32'd0);

        // START while ACTIVE is ignored (indices are not restarted)
        ahb_write(A_LEN, 32'd2);
        push_beats(PAT_A, 2);
        ahb_write(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("restart_tx_drained", tvalid, 0);
        ahb_write(A_CTRL, 32'h1);
        chk("restart_still_active", act, 1);
        chk("restart_no_tvalid", tvalid, 0);
        ahb_write(A_CTRL, 32'h2);
        ahb_read(A_STAT, 32'h20);

        // Reset in the middle of a run
        ahb_write(A_LEN, 32'd4);
        tready = 1'b0;
        ahb_write(A_CTRL, 32'h1);
        chk("midrst_active_before", act, 1);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_active", act, 0);
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_tdata", tdata, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_rx_tready", rx_tready, 1);
        chk("midrst_hrdata", hrdata, 0);
        rstn = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        ahb_read(A_LEN, 32'd0);
        ahb_read(A_PATLO, 32'd0);
        ahb_read(A_STAT, 32'd0);

`ifdef AHA_TLX_TRAIN_PRBS_EN
        // PRBS with PATTERN 0: seed becomes 1, 64 looped beats
        ahb_write(A_LEN, 32'd64);
        push_beats(40'd0, 64);
        ahb_write(A_CTRL, 32'h1);
        chk("prbs_beat0", tdata, 40'd1);
        run_loopback(-1, 200, cyc);
        chk("prbs_active_cycles", cyc, 64);
        ahb_read(A_STAT, 32'h10);
        ahb_read(A_ERR, 32'd0);
        ahb_read(A_RXC, 32'd64);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("tx_queue_drained", 64'(exp_tx_q.size()), 0);
        chk("rd_queue_drained", 64'(exp_rd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
